hack_alu: RTL and testbench

//   Hack-style 16-bit ALU with registered outputs. Datapath core of the CPU.
//   - Six control bits select from the Hack function set on operands X and Y.
//   - Result plus zero/negative status flags are registered, 1-cycle latency.
//   - Accepts a new operation every cycle.

---
 rtl/hack_alu_pkg.sv | 35 +++
 rtl/hack_alu_core.sv | 39 +++
 rtl/hack_alu.sv | 81 ++++++++
 tb/tb_hack_alu.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/hack_alu_pkg.sv
// Shared types and control encodings for the Hack ALU.
// Control constants follow the classic Hack zx,nx,zy,ny,f,no order.
package hack_alu_pkg;

    localparam int HACK_W = 16;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    localparam alu_ctrl_t C_ZERO    = 6'b101010;
    localparam alu_ctrl_t C_ONE     = 6'b111111;
    localparam alu_ctrl_t C_MINUS1  = 6'b111010;
    localparam alu_ctrl_t C_X       = 6'b001100;
    localparam alu_ctrl_t C_Y       = 6'b110000;
    localparam alu_ctrl_t C_NOTX    = 6'b001101;
    localparam alu_ctrl_t C_NOTY    = 6'b110001;
    localparam alu_ctrl_t C_NEGX    = 6'b001111;
    localparam alu_ctrl_t C_NEGY    = 6'b110011;
    localparam alu_ctrl_t C_XPLUS1  = 6'b011111;
    localparam alu_ctrl_t C_YPLUS1  = 6'b110111;
    localparam alu_ctrl_t C_XMINUS1 = 6'b001110;
    localparam alu_ctrl_t C_YMINUS1 = 6'b110010;
    localparam alu_ctrl_t C_XPLUSY  = 6'b000010;
    localparam alu_ctrl_t C_XMINUSY = 6'b010011;
    localparam alu_ctrl_t C_YMINUSX = 6'b000111;
    localparam alu_ctrl_t C_XANDY   = 6'b000000;
    localparam alu_ctrl_t C_XORY    = 6'b010101;

endpackage

// File: rtl/hack_alu_core.sv
// Combinational Hack ALU datapath: operand conditioning, add/and, negate.
// Optional signed-overflow output exists only with HACK_ALU_OVF_EN.
module hack_alu_core
    import hack_alu_pkg::*;
#(
    parameter int WIDTH = HACK_W
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  alu_ctrl_t        i_ctrl,
`ifdef HACK_ALU_OVF_EN
    output logic             o_ovf,
`endif
    output logic [WIDTH-1:0] o_res
);

    logic [WIDTH-1:0] w_xa;
    logic [WIDTH-1:0] w_xb;
    logic [WIDTH-1:0] w_ya;
    logic [WIDTH-1:0] w_yb;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_r;

    assign w_xa  = i_ctrl.zx ? '0 : i_x;
    assign w_xb  = i_ctrl.nx ? ~w_xa : w_xa;
    assign w_ya  = i_ctrl.zy ? '0 : i_y;
    assign w_yb  = i_ctrl.ny ? ~w_ya : w_ya;
    assign w_sum = w_xb + w_yb;
    assign w_r   = i_ctrl.f ? w_sum : (w_xb & w_yb);
    assign o_res = i_ctrl.no ? ~w_r : w_r;

`ifdef HACK_ALU_OVF_EN
    // Overflow judged on the raw sum; the output negate does not affect it.
    assign o_ovf = i_ctrl.f
                 & (w_xb[WIDTH-1] == w_yb[WIDTH-1])
                 & (w_sum[WIDTH-1] != w_xb[WIDTH-1]);
`endif

endmodule

// File: rtl/hack_alu.sv
// Hack ALU with registered result and NG/ZR flags, 1-cycle latency.
// Define HACK_ALU_OVF_EN to add the registered OVF output.
module hack_alu
    import hack_alu_pkg::*;
#(
    parameter int WIDTH = HACK_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             ZX,
    input  logic             NX,
    input  logic             ZY,
    input  logic             NY,
    input  logic             F,
    input  logic             NO,
`ifdef HACK_ALU_OVF_EN
    output logic             OVF,
`endif
    output logic [WIDTH-1:0] OUT,
    output logic             NG,
    output logic             ZR
);

    alu_ctrl_t        w_ctrl;
    logic [WIDTH-1:0] w_o;
    logic [WIDTH-1:0] r_out;
    logic             r_ng;
    logic             r_zr;

    assign w_ctrl = '{zx: ZX, nx: NX, zy: ZY, ny: NY, f: F, no: NO};

`ifdef HACK_ALU_OVF_EN
    logic w_ovf;
    logic r_ovf;

    hack_alu_core #(.WIDTH(WIDTH)) u_core (
        .i_x    (X),
        .i_y    (Y),
        .i_ctrl (w_ctrl),
        .o_ovf  (w_ovf),
        .o_res  (w_o)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_ovf;
        end
    end

    assign OVF = r_ovf;
`else
    hack_alu_core #(.WIDTH(WIDTH)) u_core (
        .i_x    (X),
        .i_y    (Y),
        .i_ctrl (w_ctrl),
        .o_res  (w_o)
    );
`endif

    // Flags come from the same o that is captured, so NG and ZR never collide.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out <= '0;
            r_ng  <= 1'b0;
            r_zr  <= 1'b1;
        end else begin
            r_out <= w_o;
            r_ng  <= w_o[WIDTH-1];
            r_zr  <= (w_o == '0);
        end
    end

    assign OUT = r_out;
    assign NG  = r_ng;
    assign ZR  = r_zr;

endmodule

// File: tb/tb_hack_alu.sv
// Scoreboard bench for hack_alu: directed cases plus random traffic.
// Expected values come from an integer-arithmetic model of the Hack ALU.
module tb_hack_alu;
    import hack_alu_pkg::*;

    typedef struct {
        int    out;
        bit    ng;
        bit    zr;
        bit    ovf;
        string tag;
    } exp_t;

    logic        CLK;
    logic        RST;
    logic [15:0] X;
    logic [15:0] Y;
    logic        ZX, NX, ZY, NY, F, NO;
    logic [15:0] OUT;
    logic        NG;
    logic        ZR;
`ifdef HACK_ALU_OVF_EN
    logic        OVF;
`endif

    exp_t sb[$];
    int   n_chk;
    int   n_pass;

    hack_alu #(.WIDTH(16)) dut (
        .CLK (CLK),
        .RST (RST),
        .X   (X),
        .Y   (Y),
        .ZX  (ZX),
        .NX  (NX),
        .ZY  (ZY),
        .NY  (NY),
        .F   (F),
        .NO  (NO),
`ifdef HACK_ALU_OVF_EN
        .OVF (OVF),
`endif
        .OUT (OUT),
        .NG  (NG),
        .ZR  (ZR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: unsigned integers in [0,65535]; ~v is 65535-v.
    function automatic exp_t model(bit rst, int x, int y, alu_ctrl_t c,
                                   string tag);
        exp_t e;
        int xa, xb, ya, yb, r, o, sx, sy, s;
        e.tag = tag;
        if (rst) begin
            e.out = 0; e.ng = 0; e.zr = 1; e.ovf = 0;
            return e;
        end
        xa = c.zx ? 0 : x;
        xb = c.nx ? 65535 - xa : xa;
        ya = c.zy ? 0 : y;
        yb = c.ny ? 65535 - ya : ya;
        r  = c.f ? (xb + yb) % 65536 : (xb & yb);
        o  = c.no ? 65535 - r : r;
        sx = (xb >= 32768) ? xb - 65536 : xb;
        sy = (yb >= 32768) ? yb - 65536 : yb;
        s  = sx + sy;
        e.out = o;
        e.ng  = (o >= 32768);
        e.zr  = (o == 0);
        e.ovf = c.f && (s > 32767 || s < -32768);
        return e;
    endfunction

    task automatic drive(bit rst, logic [15:0] x, logic [15:0] y,
                         alu_ctrl_t c, string tag);
        RST = rst;
        X   = x;
        Y   = y;
        ZX  = c.zx; NX = c.nx; ZY = c.zy;
        NY  = c.ny; F  = c.f;  NO = c.no;
        sb.push_back(model(rst, int'(x), int'(y), c, tag));
        @(negedge CLK);
    endtask

    task automatic check(string name, string tag, int act, int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s.%s actual=0x%0h required=0x%0h",
                      tag, name, act, req);
    endtask

    // Monitor: one registered result per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("OUT", e.tag, int'(OUT), e.out);
                check("NG",  e.tag, int'(NG),  int'(e.ng));
                check("ZR",  e.tag, int'(ZR),  int'(e.zr));
`ifdef HACK_ALU_OVF_EN
                check("OVF", e.tag, int'(OVF), int'(e.ovf));
`endif
            end
        end
    end

    initial begin
        alu_ctrl_t c;
        logic [15:0] rx, ry;
        logic [15:0] edges [6];
        int wait_cyc;
        n_chk  = 0;
        n_pass = 0;
        edges[0] = 16'h7FFF; edges[1] = 16'h8000; edges[2] = 16'hFFFF;
        edges[3] = 16'h0000; edges[4] = 16'h0001; edges[5] = 16'h8001;

        drive(1, 16'h1234, 16'h4321, C_XPLUSY, "rst0");
        drive(1, 16'h1234, 16'h4321, C_XPLUSY, "rst1");
        drive(0, 16'h1234, 16'h4321, C_XANDY,  "and");
        drive(0, 16'h1234, 16'h4321, C_XPLUSY, "add");
        drive(0, 16'h1234, 16'h4321, 6'b101010, "addzero");
        drive(0, 16'h1234, 16'h4321, C_XMINUSY, "xmy");
        drive(0, 16'h1234, 16'h4321, C_XORY,   "xory");
        drive(0, 16'h1234, 16'h4321, C_YMINUSX, "ymx");
        drive(0, 16'h7FFF, 16'h0001, C_XPLUSY, "ovfpos");
        drive(0, 16'hFFFF, 16'h0001, C_XPLUSY, "wrap0");
        drive(0, 16'h8000, 16'h8000, C_XPLUSY, "ovfneg");
        drive(0, 16'h8000, 16'hFFFF, C_XPLUSY, "ovfneg2");
        drive(0, 16'h7FFF, 16'h0001, 6'b000011, "ovfno");
        drive(0, 16'h5A5A, 16'hA5A5, C_ONE,    "one");
        drive(0, 16'h5A5A, 16'hA5A5, C_MINUS1, "minus1");
        drive(0, 16'h5A5A, 16'hA5A5, C_NEGX,   "negx");
        drive(0, 16'h5A5A, 16'hA5A5, C_YMINUS1, "ym1");
        drive(1, 16'hFFFF, 16'hFFFF, C_MINUS1, "rstmid");
        drive(0, 16'h0003, 16'h0005, C_XPLUSY, "postrst");

        for (int i = 0; i < 300; i++) begin
            rx = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)]
                                             : 16'($urandom);
            ry = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)]
                                             : 16'($urandom);
            c  = alu_ctrl_t'($urandom_range(0, 63));
            drive(($urandom_range(0, 29) == 0), rx, ry, c, "rand");
        end

        RST = 1'b0;
        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 8) begin
            @(posedge CLK);
            #2;
            wait_cyc++;
        end
        if (sb.size() > 0) begin
            n_chk++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
